// File: rtl/comp3_pkg.sv
// rtl/comp3_pkg.sv - shared types, constants and golden compare function for the comp3 sweep checker
package comp3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int VEC_COUNT = 64;
    localparam int IDX_W     = 6;

    // Golden 3-bit unsigned compare, packed as {l, e, g}
    function automatic logic [2:0] comp3_expect(input logic [2:0] a, input logic [2:0] b);
        return {(a < b), (a == b), (a > b)};
    endfunction

endpackage

// File: rtl/comp3_ref_model.sv
// rtl/comp3_ref_model.sv - combinational golden model of the 3-bit magnitude comparator
module comp3_ref_model
    import comp3_pkg::*;
(
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] leg
);

    assign leg = comp3_expect(a, b);

endmodule

// File: rtl/comp3_sweep_checker.sv
// rtl/comp3_sweep_checker.sv - exhaustive operand sweep and l/e/g checker for the 3-bit comparator
module comp3_sweep_checker
    import comp3_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] a,
    output logic [2:0] b,
    input  logic       l,
    input  logic       e,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_a,
    output logic [2:0] fail_b
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(VEC_COUNT - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [3:0]       settle_cnt;
    logic [2:0]       exp_leg;
    logic             mismatch;
    logic [6:0]       err_next;

    comp3_ref_model u_ref (
        .a   (a),
        .b   (b),
        .leg (exp_leg)
    );

    assign idx_inc  = idx + 6'd1;
    assign mismatch = ({l, e, g} != exp_leg);
    assign err_next = mismatch ? (err_count + 7'd1) : err_count;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start only accepted when no sweep is running
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      if (settle_cnt == SETTLE_LAST) state_next = CHECK;
            CHECK:      state_next = (idx == LAST_IDX) ? DONE : DRIVE;
            default:    state_next = IDLE;
        endcase
    end

    // Sweep datapath: operand drive, settle timing, error tally and first-fail capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            a          <= '0;
            b          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= '0;
                        settle_cnt <= '0;
                        a          <= '0;
                        b          <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a;
                        fail_b     <= b;
                    end
                    if (idx == LAST_IDX) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_next == 7'd0);
                        a    <= '0;
                        b    <= '0;
                    end else begin
                        idx        <= idx_inc;
                        settle_cnt <= '0;
                        a          <= idx_inc[5:3];
                        b          <= idx_inc[2:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
